// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: maps the VGA beam position to sprite-local LUT
// coordinates, picks the active frame's palette index through a 2-stage
// pipeline, and steps the animation frame on vsync in loop or ping-pong order.
module sprite_anim_ctrl #(
  parameter int X0         = 256,
  parameter int Y0         = 176,
  parameter int SCALE_LOG2 = 2,
  parameter int HOLD       = 4,
  parameter int TRANSP_EN  = 1,
  parameter int TRANSP_IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       vsync,
  input  logic       run,
  input  logic       pingpong,
  output logic [4:0] lut_x,
  output logic [4:0] lut_y,
  input  logic [2:0] pixel0,
  input  logic [2:0] pixel1,
  input  logic [2:0] pixel2,
  input  logic [2:0] pixel3,
  output logic [1:0] frame_sel,
  output logic [2:0] pix_idx,
  output logic       pix_valid,
  output logic       frame_wrap
);

  localparam int BOX = 32 << SCALE_LOG2;
  localparam logic [10:0] X0_W = 11'(X0);
  localparam logic [10:0] XE_W = 11'(X0 + BOX);
  localparam logic [10:0] Y0_W = 11'(Y0);
  localparam logic [10:0] YE_W = 11'(Y0 + BOX);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [2:0] TIDX = 3'(TRANSP_IDX);

  typedef enum logic {FWD, REV} state_t;

  // pipeline registers
  logic [4:0] lut_x_reg, lut_y_reg, lut_x_next, lut_y_next;
  logic       inside_q_reg, inside_next;
  logic [1:0] fsel_q_reg;
  logic [2:0] pix_idx_reg, pix_idx_next;
  logic       pix_valid_reg, pix_valid_next;

  // sequencer registers
  state_t        state_reg, state_next;
  logic [1:0]    frame_reg, frame_next;
  logic [HW-1:0] hold_cnt_reg, hold_next;
  logic          vs_q_reg;
  logic          wrap_reg, wrap_next;

  logic [10:0] dx, dy;
  logic        inside_x, inside_y;
  logic [2:0]  sel;
  logic        vs_rise, hold_last, advance;

  assign dx       = {1'b0, hpos} - X0_W;
  assign dy       = {1'b0, vpos} - Y0_W;
  assign inside_x = ({1'b0, hpos} >= X0_W) && ({1'b0, hpos} < XE_W);
  assign inside_y = ({1'b0, vpos} >= Y0_W) && ({1'b0, vpos} < YE_W);

  // stage 1: box test and downscaled sprite coordinates (0 outside the box)
  always_comb begin
    inside_next = inside_x & inside_y;
    lut_x_next  = '0;
    lut_y_next  = '0;
    if (inside_next) begin
      lut_x_next = dx[SCALE_LOG2+4:SCALE_LOG2];
      lut_y_next = dy[SCALE_LOG2+4:SCALE_LOG2];
    end
  end

  // stage 2: frame mux uses the stage-1 snapshot so a frame change never tears a pixel
  always_comb begin
    case (fsel_q_reg)
      2'd0:    sel = pixel0;
      2'd1:    sel = pixel1;
      2'd2:    sel = pixel2;
      default: sel = pixel3;
    endcase
    pix_idx_next   = inside_q_reg ? sel : 3'd0;
    pix_valid_next = inside_q_reg & ~((TRANSP_EN != 0) && (sel == TIDX));
  end

  // pixel pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_x_reg     <= '0;
      lut_y_reg     <= '0;
      inside_q_reg  <= 1'b0;
      fsel_q_reg    <= '0;
      pix_idx_reg   <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      lut_x_reg     <= lut_x_next;
      lut_y_reg     <= lut_y_next;
      inside_q_reg  <= inside_next;
      fsel_q_reg    <= frame_reg;
      pix_idx_reg   <= pix_idx_next;
      pix_valid_reg <= pix_valid_next;
    end
  end

  assign vs_rise   = vsync & ~vs_q_reg;
  assign hold_last = (hold_cnt_reg == HOLD_LAST);
  assign advance   = vs_rise & run & hold_last;

  // hold counter and frame sequencer next-state
  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    hold_next  = hold_cnt_reg;
    if (vs_rise && run) begin
      hold_next = hold_last ? '0 : hold_cnt_reg + 1'b1;
    end
    if (advance) begin
      if (!pingpong) begin
        state_next = FWD;
        frame_next = frame_reg + 2'd1;
      end else if (state_reg == FWD) begin
        if (frame_reg == 2'd3) begin
          state_next = REV;
          frame_next = 2'd2;
        end else begin
          frame_next = frame_reg + 2'd1;
        end
      end else begin
        if (frame_reg == 2'd0) begin
          state_next = FWD;
          frame_next = 2'd1;
        end else begin
          frame_next = frame_reg - 2'd1;
        end
      end
    end
    wrap_next = advance && (frame_next == 2'd0);
  end

  // sequencer state register; vs_q resets high so a vsync held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FWD;
      frame_reg    <= '0;
      hold_cnt_reg <= '0;
      vs_q_reg     <= 1'b1;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      hold_cnt_reg <= hold_next;
      vs_q_reg     <= vsync;
      wrap_reg     <= wrap_next;
    end
  end

  assign lut_x      = lut_x_reg;
  assign lut_y      = lut_y_reg;
  assign pix_idx    = pix_idx_reg;
  assign pix_valid  = pix_valid_reg;
  assign frame_sel  = frame_reg;
  assign frame_wrap = wrap_reg;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl: table of mapping/boundary vectors plus
// hand-written vsync sequences for loop, ping-pong, freeze and reset.
module tb_sprite_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       vsync, run, pingpong;
  logic [4:0] lut_x, lut_y;
  logic [2:0] pixel0, pixel1, pixel2, pixel3;
  logic [1:0] frame_sel;
  logic [2:0] pix_idx;
  logic       pix_valid, frame_wrap;

  int total = 0;
  int bad   = 0;

  sprite_anim_ctrl dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .run(run), .pingpong(pingpong), .lut_x(lut_x), .lut_y(lut_y),
    .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
    .frame_sel(frame_sel), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .frame_wrap(frame_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] p1;
    logic [4:0] ex;
    logic [4:0] ey;
    logic [2:0] eidx;
    logic       ev;
  } vec_t;

  vec_t vecs [10];
  int   pp_seq [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // one vsync pulse; checks wrap in the cycle after the rise and the settled frame
  task automatic pulse(input string tag, input int exp_frame, input int exp_wrap);
    vsync = 1'b1;
    @(negedge clk);
    chk({tag, " wrap"}, frame_wrap, exp_wrap);
    vsync = 1'b0;
    @(negedge clk);
    chk({tag, " wrap_end"}, frame_wrap, 0);
    chk({tag, " frame"}, frame_sel, exp_frame);
    $display("pulse %s: frame_sel=%0d exp=%0d", tag, frame_sel, exp_frame);
  endtask

  initial begin
    // mapping / boundary vectors, evaluated with frame_sel=1
    vecs[0] = '{10'd279,  10'd204,  3'd6, 5'd5,  5'd7,  3'd6, 1'b1};
    vecs[1] = '{10'd255,  10'd204,  3'd6, 5'd0,  5'd0,  3'd0, 1'b0};
    vecs[2] = '{10'd383,  10'd204,  3'd4, 5'd31, 5'd7,  3'd4, 1'b1};
    vecs[3] = '{10'd384,  10'd204,  3'd4, 5'd0,  5'd0,  3'd0, 1'b0};
    vecs[4] = '{10'd300,  10'd303,  3'd2, 5'd11, 5'd31, 3'd2, 1'b1};
    vecs[5] = '{10'd300,  10'd304,  3'd2, 5'd0,  5'd0,  3'd0, 1'b0};
    vecs[6] = '{10'd256,  10'd176,  3'd0, 5'd0,  5'd0,  3'd0, 1'b0};
    vecs[7] = '{10'd0,    10'd0,    3'd7, 5'd0,  5'd0,  3'd0, 1'b0};
    vecs[8] = '{10'd320,  10'd240,  3'd7, 5'd16, 5'd16, 3'd7, 1'b1};
    vecs[9] = '{10'd1023, 10'd1023, 3'd7, 5'd0,  5'd0,  3'd0, 1'b0};
    pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    rst = 1'b1; hpos = 10'd279; vpos = 10'd204; vsync = 1'b0;
    run = 1'b1; pingpong = 1'b0;
    pixel0 = 3'd1; pixel1 = 3'd6; pixel2 = 3'd3; pixel3 = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst lut_x", lut_x, 0);
    chk("rst lut_y", lut_y, 0);
    chk("rst frame_sel", frame_sel, 0);
    chk("rst pix_idx", pix_idx, 0);
    chk("rst pix_valid", pix_valid, 0);
    chk("rst frame_wrap", frame_wrap, 0);
    $display("reset: outputs checked");
    rst = 1'b0;

    // frame 0: transparent index, then opaque index through the frame-0 mux
    pixel0 = 3'd0;
    repeat (2) @(negedge clk);
    chk("f0 transp idx", pix_idx, 0);
    chk("f0 transp valid", pix_valid, 0);
    pixel0 = 3'd3;
    @(negedge clk);
    chk("f0 opaque idx", pix_idx, 3);
    chk("f0 opaque valid", pix_valid, 1);
    $display("frame0 pixel: idx=%0d valid=%0d", pix_idx, pix_valid);
    pixel0 = 3'd1;

    // loop order: advance every 4th rise, single wrap at rise 16
    for (int i = 1; i <= 16; i++)
      pulse($sformatf("loop%0d", i), (i / 4) % 4, (i == 16) ? 1 : 0);

    // ping-pong order: 1,2,3,2,1,0,1 at every 4th rise, wrap only at rise 24
    pingpong = 1'b1;
    for (int i = 1; i <= 28; i++)
      pulse($sformatf("pp%0d", i), pp_seq[i / 4], (i == 24) ? 1 : 0);

    // pixel mapping table at frame_sel=1
    for (int i = 0; i < 10; i++) begin
      hpos = vecs[i].h; vpos = vecs[i].v; pixel1 = vecs[i].p1;
      @(negedge clk);
      chk($sformatf("vec%0d lut_x", i), lut_x, vecs[i].ex);
      chk($sformatf("vec%0d lut_y", i), lut_y, vecs[i].ey);
      @(negedge clk);
      chk($sformatf("vec%0d pix_idx", i), pix_idx, vecs[i].eidx);
      chk($sformatf("vec%0d pix_valid", i), pix_valid, vecs[i].ev);
      $display("vec %0d: h=%0d v=%0d lut=(%0d,%0d) idx=%0d valid=%0d",
               i, vecs[i].h, vecs[i].v, lut_x, lut_y, pix_idx, pix_valid);
    end

    // freeze: two counted rises, ten ignored, then advance on the 2nd new rise
    hpos = 10'd0; vpos = 10'd0;
    pulse("frz_a1", 1, 0);
    pulse("frz_a2", 1, 0);
    run = 1'b0;
    for (int i = 1; i <= 10; i++) pulse($sformatf("frz_off%0d", i), 1, 0);
    run = 1'b1;
    pulse("frz_b1", 1, 0);
    pulse("frz_b2", 2, 0);

    // walk to frame 2 in REV: 2 -> 3 -> 2
    for (int i = 1; i <= 8; i++)
      pulse($sformatf("walk%0d", i), (i < 4) ? 2 : ((i < 8) ? 3 : 2), 0);
    pulse("mid1", 2, 0);
    pulse("mid2", 2, 0);

    // fill the pixel pipeline with a visible pixel, then reset with vsync high
    hpos = 10'd279; vpos = 10'd204;
    repeat (3) @(negedge clk);
    chk("pre_rst valid", pix_valid, 1);
    chk("pre_rst idx", pix_idx, 3);
    vsync = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst lut_x", lut_x, 0);
    chk("mid_rst lut_y", lut_y, 0);
    chk("mid_rst frame_sel", frame_sel, 0);
    chk("mid_rst pix_idx", pix_idx, 0);
    chk("mid_rst pix_valid", pix_valid, 0);
    chk("mid_rst frame_wrap", frame_wrap, 0);
    $display("mid reset: outputs checked");
    rst = 1'b0; hpos = 10'd0; vpos = 10'd0;
    repeat (3) begin
      @(negedge clk);
      chk("held_vs frame", frame_sel, 0);
      chk("held_vs wrap", frame_wrap, 0);
    end
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    chk("vs_fall frame", frame_sel, 0);
    chk("vs_fall wrap", frame_wrap, 0);
    pulse("post1", 0, 0);
    pulse("post2", 0, 0);
    pulse("post3", 0, 0);
    pulse("post4", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
